// File: rtl/compress_frame_arbiter_if.sv
// Handshake bundle between the snapshot request sources, the frame arbiter
// and the image compressor. The master side drives requests and scan control;
// the slave side (the arbiter) returns scan position and frame status.
interface compress_frame_arbiter_if #(
  parameter int ADDR_W  = 8,
  parameter int NUM_REQ = 2,
  parameter int GID_W   = $clog2(NUM_REQ + 1)
);
  logic [NUM_REQ-1:0] req_we;
  logic [NUM_REQ-1:0] req_wdata;
  logic               cont_mode;
  logic               stall;
  logic [ADDR_W-1:0]  scan_x;
  logic [ADDR_W-1:0]  scan_y;
  logic               compress_start;
  logic               busy;
  logic               frame_done;
  logic [NUM_REQ-1:0] req_pending;
  logic [GID_W-1:0]   grant_id;
  logic [15:0]        frame_cnt;

  modport master (
    output req_we, req_wdata, cont_mode, stall,
    input  scan_x, scan_y, compress_start, busy, frame_done,
           req_pending, grant_id, frame_cnt
  );

  modport slave (
    input  req_we, req_wdata, cont_mode, stall,
    output scan_x, scan_y, compress_start, busy, frame_done,
           req_pending, grant_id, frame_cnt
  );
endinterface

// File: rtl/compress_frame_arbiter.sv
// Raster scan counter plus frame-aligned arbiter for sticky snapshot requests.
// A capture frame may only begin on the scan wrap back to pixel (0,0); the
// lowest-numbered pending requester wins, or continuous mode claims the frame
// (grant_id = NUM_REQ) when nothing is pending. All outputs are registered.
module compress_frame_arbiter #(
  parameter int IMG_W   = 224,
  parameter int IMG_H   = 224,
  parameter int ADDR_W  = 8,
  parameter int NUM_REQ = 2,
  parameter int GID_W   = $clog2(NUM_REQ + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  compress_frame_arbiter_if.slave bus
);

  logic [ADDR_W-1:0]  scan_x;
  logic [ADDR_W-1:0]  scan_y;
  logic               compress_start;
  logic               busy;
  logic               frame_done;
  logic [NUM_REQ-1:0] req_pending;
  logic [GID_W-1:0]   grant_id;
  logic [15:0]        frame_cnt;

  logic               adv;
  logic               x_last;
  logic               y_last;
  logic               wrap;
  logic               eligible;
  logic [NUM_REQ-1:0] grant_mask;
  logic [GID_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] pending_next;

  assign adv      = !bus.stall;
  assign x_last   = (scan_x == ADDR_W'(IMG_W - 1));
  assign y_last   = (scan_y == ADDR_W'(IMG_H - 1));
  assign wrap     = adv && x_last && y_last;
  assign eligible = bus.cont_mode || (|req_pending);

  // Isolate the lowest set pending bit; this is the bit a grant consumes.
  assign grant_mask = req_pending & (~req_pending + NUM_REQ'(1));

  // Lowest pending index wins; NUM_REQ marks a continuous-mode frame.
  always_comb begin
    grant_idx = GID_W'(NUM_REQ);
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_pending[i]) grant_idx = GID_W'(i);
    end
  end

  // Next request bits: a grant clears its bit, but a same-cycle write wins.
  always_comb begin
    pending_next = req_pending;
    if (wrap && eligible) pending_next = pending_next & ~grant_mask;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_we[i]) pending_next[i] = bus.req_wdata[i];
    end
  end

  // Scan counters, frame start/end pulses, request bits and frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_x         <= '0;
      scan_y         <= '0;
      compress_start <= 1'b0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      req_pending    <= '0;
      grant_id       <= '0;
      frame_cnt      <= '0;
    end else begin
      compress_start <= 1'b0;
      frame_done     <= 1'b0;
      req_pending    <= pending_next;
      if (adv) begin
        if (x_last) begin
          scan_x <= '0;
          scan_y <= y_last ? '0 : scan_y + ADDR_W'(1);
        end else begin
          scan_x <= scan_x + ADDR_W'(1);
        end
        // Frame boundary: close the running frame and possibly open the next.
        if (wrap) begin
          compress_start <= eligible;
          frame_done     <= busy;
          busy           <= eligible;
          if (busy) frame_cnt <= frame_cnt + 16'd1;
          if (eligible) grant_id <= grant_idx;
        end
      end
    end
  end

  assign bus.scan_x         = scan_x;
  assign bus.scan_y         = scan_y;
  assign bus.compress_start = compress_start;
  assign bus.busy           = busy;
  assign bus.frame_done     = frame_done;
  assign bus.req_pending    = req_pending;
  assign bus.grant_id       = grant_id;
  assign bus.frame_cnt      = frame_cnt;

endmodule

// File: tb/tb_compress_frame_arbiter.sv
// Bench for compress_frame_arbiter on a 4x3 image with two requesters.
// A table of timed steps drives the requests/modes and holds the expected
// outputs after each step; expected grant ids go into a queue when the
// request is driven and are popped whenever compress_start is seen.
module tb_compress_frame_arbiter;

  localparam int IMG_W   = 4;
  localparam int IMG_H   = 3;
  localparam int ADDR_W  = 8;
  localparam int NUM_REQ = 2;
  localparam int GID_W   = 2;

  typedef struct {
    int we, wd, cont, stall, n, push0, push1;
    int x, y, st, bz, dn, pd, gid, cnt;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   done_seen;
  int   exp_q[$];
  vec_t tbl[$];
  vec_t zero_v;

  compress_frame_arbiter_if #(.ADDR_W(ADDR_W), .NUM_REQ(NUM_REQ), .GID_W(GID_W)) bus ();

  compress_frame_arbiter #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .NUM_REQ(NUM_REQ), .GID_W(GID_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(int we, int wd, int cont, int stall, int n, int push0, int push1,
                              int x, int y, int st, int bz, int dn, int pd, int gid, int cnt);
    vec_t v;
    v.we = we; v.wd = wd; v.cont = cont; v.stall = stall; v.n = n;
    v.push0 = push0; v.push1 = push1;
    v.x = x; v.y = y; v.st = st; v.bz = bz; v.dn = dn; v.pd = pd; v.gid = gid; v.cnt = cnt;
    return v;
  endfunction

  // One clock: watch the start/done pulses at the falling edge, then advance.
  task automatic step();
    int e;
    @(negedge clk);
    if (bus.compress_start) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL start_grant: unexpected compress_start grant_id=%0d, none required", bus.grant_id);
      end else begin
        e = exp_q.pop_front();
        if (int'(bus.grant_id) != e) begin
          errors++;
          $display("FAIL start_grant: grant_id=%0d required %0d", bus.grant_id, e);
        end
      end
    end
    if (bus.frame_done) done_seen++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(string name, vec_t v);
    checks++;
    if (int'(bus.scan_x) != v.x || int'(bus.scan_y) != v.y ||
        int'(bus.compress_start) != v.st || int'(bus.busy) != v.bz ||
        int'(bus.frame_done) != v.dn || int'(bus.req_pending) != v.pd ||
        int'(bus.grant_id) != v.gid || int'(bus.frame_cnt) != v.cnt) begin
      errors++;
      $display("FAIL %s: got x=%0d y=%0d st=%0d busy=%0d done=%0d pend=%0d gid=%0d cnt=%0d required x=%0d y=%0d st=%0d busy=%0d done=%0d pend=%0d gid=%0d cnt=%0d",
               name, bus.scan_x, bus.scan_y, bus.compress_start, bus.busy, bus.frame_done,
               bus.req_pending, bus.grant_id, bus.frame_cnt,
               v.x, v.y, v.st, v.bz, v.dn, v.pd, v.gid, v.cnt);
    end
  endtask

  initial begin
    vec_t v;
    checks    = 0;
    errors    = 0;
    done_seen = 0;
    zero_v    = mk(0, 0, 0, 0, 0, -1, -1, 0, 0, 0, 0, 0, 0, 0, 0);

    //                we  wd  c  s   n  p0  p1   x  y st bz dn pd gid cnt
    // single request granted at the first wrap
    tbl.push_back(mk(0,  0,  0, 0,  1, -1, -1,  1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1,  1,  0, 0,  1,  0, -1,  2, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0,  0,  0, 0,  9, -1, -1,  3, 2, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0,  0,  0, 0,  1, -1, -1,  0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0,  0,  0, 0, 11, -1, -1,  3, 2, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0,  0,  0, 0,  1, -1, -1,  0, 0, 0, 0, 1, 0, 0, 1));
    // both requesters: back-to-back frames, channel 0 then channel 1
    tbl.push_back(mk(3,  3,  0, 0,  1,  0,  1,  1, 0, 0, 0, 0, 3, 0, 1));
    tbl.push_back(mk(0,  0,  0, 0, 11, -1, -1,  0, 0, 1, 1, 0, 2, 0, 1));
    tbl.push_back(mk(0,  0,  0, 0, 12, -1, -1,  0, 0, 1, 1, 1, 0, 1, 2));
    tbl.push_back(mk(0,  0,  0, 0, 12, -1, -1,  0, 0, 0, 0, 1, 0, 1, 3));
    // continuous mode, dropped mid-frame
    tbl.push_back(mk(0,  0,  1, 0, 12,  2, -1,  0, 0, 1, 1, 0, 0, 2, 3));
    tbl.push_back(mk(0,  0,  1, 0,  6, -1, -1,  2, 1, 0, 1, 0, 0, 2, 3));
    tbl.push_back(mk(0,  0,  1, 0,  6,  2, -1,  0, 0, 1, 1, 1, 0, 2, 4));
    tbl.push_back(mk(0,  0,  0, 0,  5, -1, -1,  1, 1, 0, 1, 0, 0, 2, 4));
    tbl.push_back(mk(0,  0,  0, 0,  7, -1, -1,  0, 0, 0, 0, 1, 0, 2, 5));
    // request rewritten on the grant-clear edge: write wins
    tbl.push_back(mk(1,  1,  0, 0, 11,  0, -1,  3, 2, 0, 0, 0, 1, 2, 5));
    tbl.push_back(mk(1,  1,  0, 0,  1,  0, -1,  0, 0, 1, 1, 0, 1, 0, 5));
    tbl.push_back(mk(0,  0,  0, 0, 12, -1, -1,  0, 0, 1, 1, 1, 0, 0, 6));
    // stall for 5 cycles at (2,1) delays frame_done by 5
    tbl.push_back(mk(0,  0,  0, 0,  6, -1, -1,  2, 1, 0, 1, 0, 0, 0, 6));
    tbl.push_back(mk(0,  0,  0, 1,  5, -1, -1,  2, 1, 0, 1, 0, 0, 0, 6));
    tbl.push_back(mk(0,  0,  0, 0,  5, -1, -1,  3, 2, 0, 1, 0, 0, 0, 6));
    tbl.push_back(mk(0,  0,  0, 0,  1, -1, -1,  0, 0, 0, 0, 1, 0, 0, 7));
    // start a frame and leave channel 1 pending, ready for a mid-frame reset
    tbl.push_back(mk(1,  1,  0, 0, 11,  0, -1,  3, 2, 0, 0, 0, 1, 0, 7));
    tbl.push_back(mk(0,  0,  0, 0,  1, -1, -1,  0, 0, 1, 1, 0, 0, 0, 7));
    tbl.push_back(mk(2,  2,  0, 0,  7, -1, -1,  3, 1, 0, 1, 0, 2, 0, 7));

    rst           = 1'b1;
    bus.req_we    = '0;
    bus.req_wdata = '0;
    bus.cont_mode = 1'b0;
    bus.stall     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset_state", zero_v);
    rst = 1'b0;

    foreach (tbl[i]) begin
      v = tbl[i];
      bus.req_we    = NUM_REQ'(v.we);
      bus.req_wdata = NUM_REQ'(v.wd);
      bus.cont_mode = v.cont[0];
      bus.stall     = v.stall[0];
      if (v.push0 >= 0) exp_q.push_back(v.push0);
      if (v.push1 >= 0) exp_q.push_back(v.push1);
      step();
      bus.req_we    = '0;
      bus.req_wdata = '0;
      repeat (v.n - 1) step();
      check_state($sformatf("row%0d", i), v);
    end

    // Reset between clock edges while busy at (3,1): state clears at once.
    #3 rst = 1'b1;
    #1;
    check_state("async_reset_mid_frame", zero_v);
    #2;
    repeat (3) step();
    rst = 1'b0;
    // A full scan after release must not start a frame: nothing is eligible.
    repeat (IMG_W * IMG_H) step();
    check_state("post_reset_scan", zero_v);

    checks++;
    if (done_seen != 7) begin
      errors++;
      $display("FAIL frame_done_pulses: saw %0d required 7", done_seen);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_starts: %0d expected starts never seen, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
